// File: rtl/arb2_pkg.sv
// arb2_pkg: shared state encoding and grant constants for the 2-source arbiter stage
package arb2_pkg;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;
   localparam logic LAST_GRANT_RST = 1'b1;
endpackage

// File: rtl/arb2_grant.sv
// arb2_grant: combinational 2-way grant; ARB_FIXED_PRIO_EN makes source 0 win ties
module arb2_grant
   import arb2_pkg::*;
(
   input  logic in0_valid,
   input  logic in1_valid,
   input  logic last_grant,
   output logic gnt,
   output logic any_req
);
`ifdef ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   always_comb begin
      any_req = in0_valid | in1_valid;
      gnt = in0_valid ? SRC0 : SRC1;
   end
`else
   always_comb begin
      any_req = in0_valid | in1_valid;
      gnt = (in0_valid & in1_valid) ? ~last_grant : (in0_valid ? SRC0 : SRC1);
   end
`endif
endmodule

// File: rtl/arb2_rr_stage.sv
// arb2_rr_stage: round-robin 2:1 arbiter with one-entry output register; ARB_FIXED_PRIO_EN selects fixed priority
module arb2_rr_stage
   import arb2_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in0_valid,
   output logic          in0_ready,
   input  logic [DW-1:0] in0_data,
   input  logic          in1_valid,
   output logic          in1_ready,
   input  logic [DW-1:0] in1_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          sel
);
   state_t state;
   logic last_grant, gnt, any_req, accept, take;
   arb2_grant u_grant (
      .in0_valid (in0_valid),
      .in1_valid (in1_valid),
      .last_grant(last_grant),
      .gnt       (gnt),
      .any_req   (any_req)
   );
   assign out_valid = state == FULL;
   assign accept    = rst_n & ((state == EMPTY) | out_ready);
   assign in0_ready = accept & in0_valid & (gnt == SRC0);
   assign in1_ready = accept & in1_valid & (gnt == SRC1);
   assign take      = accept & any_req;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         out_data   <= '0;
         sel        <= SRC0;
         last_grant <= LAST_GRANT_RST;
      end else if (take) begin
         state      <= FULL;
         out_data   <= gnt ? in1_data : in0_data;
         sel        <= gnt;
         last_grant <= gnt;
      end else if (out_valid & out_ready) begin
         state <= EMPTY;
      end
   end
endmodule
